// File: rtl/aes_host_seq.sv
// Host-side sequencer for the Custom_AES core: issues key/data, collects
// ciphertext, checks against golden, watches for hangs, counts failed runs.
module aes_host_seq #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             chain,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic [127:0]     key_cfg,
    input  logic [127:0]     pt_cfg,
    input  logic [127:0]     golden,
    output logic             EN,
    output logic [127:0]     Kin,
    output logic [127:0]     Din,
    output logic             KDrdy,
    input  logic [127:0]     Dout,
    input  logic             Dvld,
    input  logic             BSY,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             hang,
    output logic [127:0]     last_ct,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [127:0]     pt_q;
    logic [127:0]     gold_q;
    logic             chain_q;
    logic [CNT_W-1:0] nblk_q;
    logic [WD_W-1:0]  wd_q;
    logic             timeout;
    logic             last_blk;

    // KDrdy cycle plus TIMEOUT_CYC-1 WAIT cycles: FIN lands TIMEOUT_CYC after KDrdy
    assign timeout  = (wd_q == WD_W'(TIMEOUT_CYC - 2));
    assign last_blk = (blk_cnt == nblk_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!BSY) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Dvld) begin
                    state_nxt = S_NEXT;
                end else if (timeout) begin
                    state_nxt = S_FIN;
                end
            end
            S_NEXT: begin
                state_nxt = last_blk ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        KDrdy = 1'b0;
        done  = 1'b0;
        busy  = 1'b0;
        unique case (state)
            S_ISSUE: begin
                KDrdy = !BSY && !RST;
                busy  = 1'b1;
            end
            S_WAIT, S_NEXT: begin
                busy = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            EN      <= 1'b0;
            Kin     <= '0;
            Din     <= '0;
            pt_q    <= '0;
            gold_q  <= '0;
            chain_q <= 1'b0;
            nblk_q  <= '0;
            wd_q    <= '0;
            pass    <= 1'b0;
            hang    <= 1'b0;
            last_ct <= '0;
            blk_cnt <= '0;
            err_cnt <= '0;
        end else begin
            EN <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        Kin     <= key_cfg;
                        Din     <= pt_cfg;
                        pt_q    <= pt_cfg;
                        gold_q  <= golden;
                        chain_q <= chain;
                        nblk_q  <= (num_blocks == '0) ? CNT_W'(1)
                                                      : num_blocks;
                        blk_cnt <= '0;
                        pass    <= 1'b0;
                        hang    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (!BSY) begin
                        wd_q <= '0;
                    end
                end
                S_WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (Dvld) begin
                        last_ct <= Dout;
                        blk_cnt <= blk_cnt + CNT_W'(1);
                    end else if (timeout) begin
                        hang <= 1'b1;
                        pass <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (last_blk) begin
                        pass <= (last_ct == gold_q);
                    end else begin
                        Din <= chain_q ? last_ct : pt_q;
                    end
                end
                S_FIN: begin
                    if (!pass && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_seq.sv
// Directed bench for aes_host_seq: behavioural AES-128 core model plus
// FIPS-197 and chained vectors, watchdog, BSY back-pressure and reset cases.
module tb_aes_host_seq;

    localparam int T   = 64;
    localparam int CW  = 16;
    localparam int LAT = 5;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          chain;
    logic [CW-1:0] num_blocks;
    logic [127:0]  key_cfg;
    logic [127:0]  pt_cfg;
    logic [127:0]  golden;
    logic          EN;
    logic [127:0]  Kin;
    logic [127:0]  Din;
    logic          KDrdy;
    logic [127:0]  Dout;
    logic          Dvld;
    logic          BSY;
    logic          busy;
    logic          done;
    logic          pass;
    logic          hang;
    logic [127:0]  last_ct;
    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] err_cnt;

    aes_host_seq #(.TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .chain(chain),
        .num_blocks(num_blocks), .key_cfg(key_cfg), .pt_cfg(pt_cfg),
        .golden(golden), .EN(EN), .Kin(Kin), .Din(Din), .KDrdy(KDrdy),
        .Dout(Dout), .Dvld(Dvld), .BSY(BSY), .busy(busy), .done(done),
        .pass(pass), .hang(hang), .last_ct(last_ct), .blk_cnt(blk_cnt),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    // AES-128 reference
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k,
                                             input logic [127:0] p);
        logic [7:0] st [16];
        logic [7:0] tp [16];
        logic [7:0] rk [16];
        logic [7:0] rc, a0, a1, a2, a3, t0, t1, t2, t3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            st[i] = p[127-8*i -: 8];
            rk[i] = k[127-8*i -: 8];
            st[i] = st[i] ^ rk[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t0 = sb[rk[13]] ^ rc;
            t1 = sb[rk[14]];
            t2 = sb[rk[15]];
            t3 = sb[rk[12]];
            rk[0] = rk[0] ^ t0; rk[1] = rk[1] ^ t1;
            rk[2] = rk[2] ^ t2; rk[3] = rk[3] ^ t3;
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) tp[i] = sb[st[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++)
                    st[rr+4*c] = tp[rr+4*((c+rr)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1];
                    a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
        return r;
    endfunction

    // core model
    logic         bsy_force = 1'b0;
    logic         no_dvld   = 1'b0;
    logic         stray     = 1'b0;
    logic         core_busy = 1'b0;
    logic         dvld_m    = 1'b0;
    logic [127:0] dout_m    = '0;
    logic [127:0] ct_q      = '0;
    logic [127:0] k_hold    = '0;
    logic [127:0] d_hold    = '0;
    int           lat_cnt   = 0;
    int           stab_err  = 0;

    assign BSY  = bsy_force | core_busy;
    assign Dvld = dvld_m | stray;
    assign Dout = stray ? '1 : dout_m;

    always @(posedge CLK) begin
        dvld_m <= 1'b0;
        if (RST) begin
            core_busy <= 1'b0;
            lat_cnt   <= 0;
        end else if (KDrdy) begin
            core_busy <= 1'b1;
            lat_cnt   <= LAT;
            ct_q      <= aes_enc(Kin, Din);
            k_hold    <= Kin;
            d_hold    <= Din;
        end else if (core_busy) begin
            if (Kin != k_hold || Din != d_hold) stab_err <= stab_err + 1;
            if (lat_cnt == 1) begin
                core_busy <= 1'b0;
                if (!no_dvld) begin
                    dvld_m <= 1'b1;
                    dout_m <= ct_q;
                end
            end
            lat_cnt <= lat_cnt - 1;
        end
    end

    // monitor
    int           cyc      = 0;
    int           kd_n     = 0;
    int           done_n   = 0;
    int           kd_b2b   = 0;
    logic         kd_prev  = 1'b0;
    logic [127:0] kd_din [64];
    int           kd_cyc [64];

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        kd_prev <= KDrdy;
        if (KDrdy && kd_prev) kd_b2b <= kd_b2b + 1;
        if (KDrdy && kd_n < 64) begin
            kd_din[kd_n] <= Din;
            kd_cyc[kd_n] <= cyc;
            kd_n         <= kd_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cyc;
    logic pass_d;
    logic hang_d;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 2000) begin
            step();
            i++;
        end
        check({tag, "_done"}, 128'(done), 128'(1));
        check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
        done_cyc = cyc;
        pass_d   = pass;
        hang_d   = hang;
        step();
        check({tag, "_done_pulse"}, 128'(done), 128'(0));
    endtask

    task automatic run(input string tag, input logic ch,
                       input logic [CW-1:0] nb, input logic [127:0] p,
                       input logic [127:0] g, output int kd0);
        int d0;
        kd0        = kd_n;
        d0         = done_n;
        chain      = ch;
        num_blocks = nb;
        key_cfg    = KEY;
        pt_cfg     = p;
        golden     = g;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_done(tag);
        check({tag, "_done_cnt"}, 128'(done_n - d0), 128'(1));
    endtask

    logic [127:0] exp_din [4];
    logic [127:0] g4;
    int           kd0;
    int           s_cyc;
    int           i;

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
        end

        RST = 1'b1; start = 1'b0; chain = 1'b0; num_blocks = '0;
        key_cfg = '0; pt_cfg = '0; golden = '0;
        repeat (3) step();
        check("rst_en", 128'(EN), 128'(0));
        check("rst_kdrdy", 128'(KDrdy), 128'(0));
        check("rst_kin", Kin, 128'(0));
        check("rst_din", Din, 128'(0));
        check("rst_flags", 128'({busy, done, pass, hang}), 128'(0));
        check("rst_last_ct", last_ct, 128'(0));
        check("rst_cnts", 128'({blk_cnt, err_cnt}), 128'(0));
        RST = 1'b0;
        step();
        check("en_after_rst", 128'(EN), 128'(1));

        run("fips", 1'b0, 16'd1, PT, FIPS, kd0);
        check("fips_pass", 128'(pass_d), 128'(1));
        check("fips_hang", 128'(hang_d), 128'(0));
        check("fips_ct", last_ct, FIPS);
        check("fips_kd", 128'(kd_n - kd0), 128'(1));
        check("fips_blk", 128'(blk_cnt), 128'(1));
        check("fips_err", 128'(err_cnt), 128'(0));
        check("fips_kin", Kin, KEY);

        stray = 1'b1;
        step();
        stray = 1'b0;
        step();
        check("stray_ct", last_ct, FIPS);
        check("stray_blk", 128'(blk_cnt), 128'(1));

        exp_din[0] = PT;
        for (int k = 1; k < 4; k++) exp_din[k] = aes_enc(KEY, exp_din[k-1]);
        g4 = aes_enc(KEY, exp_din[3]);
        run("chain4", 1'b1, 16'd4, PT, g4, kd0);
        check("chain4_kd", 128'(kd_n - kd0), 128'(4));
        for (int k = 0; k < 4; k++)
            check($sformatf("chain4_din%0d", k), kd_din[kd0+k], exp_din[k]);
        check("chain4_pass", 128'(pass_d), 128'(1));
        check("chain4_blk", 128'(blk_cnt), 128'(4));

        run("fixed3", 1'b0, 16'd3, PT, FIPS, kd0);
        check("fixed3_kd", 128'(kd_n - kd0), 128'(3));
        check("fixed3_din2", kd_din[kd0+2], PT);
        check("fixed3_pass", 128'(pass_d), 128'(1));
        check("fixed3_blk", 128'(blk_cnt), 128'(3));

        run("nb0", 1'b0, 16'd0, PT, FIPS, kd0);
        check("nb0_kd", 128'(kd_n - kd0), 128'(1));
        check("nb0_blk", 128'(blk_cnt), 128'(1));
        check("nb0_pass", 128'(pass_d), 128'(1));

        run("flip1", 1'b0, 16'd1, PT, FIPS ^ 128'h1, kd0);
        check("flip1_pass", 128'(pass_d), 128'(0));
        check("flip1_err", 128'(err_cnt), 128'(1));
        run("flip2", 1'b0, 16'd1, PT, FIPS ^ 128'h1, kd0);
        check("flip2_err", 128'(err_cnt), 128'(2));

        no_dvld = 1'b1;
        run("hang", 1'b0, 16'd1, PT, FIPS, kd0);
        no_dvld = 1'b0;
        check("hang_flag", 128'(hang_d), 128'(1));
        check("hang_pass", 128'(pass_d), 128'(0));
        check("hang_delay", 128'(done_cyc - kd_cyc[kd0]), 128'(T));
        check("hang_err", 128'(err_cnt), 128'(3));
        check("hang_blk", 128'(blk_cnt), 128'(0));

        bsy_force = 1'b1;
        kd0 = kd_n;
        chain = 1'b0; num_blocks = 16'd1; pt_cfg = PT; golden = FIPS;
        start = 1'b1;
        s_cyc = cyc;
        for (int k = 1; k <= 10; k++) begin
            step();
            start = (k == 3 || k == 7);
        end
        step();
        start = 1'b0;
        bsy_force = 1'b0;
        wait_done("bsy");
        check("bsy_kd_cyc", 128'(kd_cyc[kd0] - s_cyc), 128'(11));
        check("bsy_kd", 128'(kd_n - kd0), 128'(1));
        check("bsy_pass", 128'(pass_d), 128'(1));
        check("bsy_err", 128'(err_cnt), 128'(3));

        kd0 = kd_n;
        start = 1'b1;
        step();
        start = 1'b0;
        i = 0;
        while (kd_n == kd0 && i < 50) begin
            step();
            i++;
        end
        check("wrst_kd_seen", 128'(kd_n - kd0), 128'(1));
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("wrst_busy", 128'(busy), 128'(0));
        check("wrst_kdrdy", 128'(KDrdy), 128'(0));
        check("wrst_blk", 128'(blk_cnt), 128'(0));
        check("wrst_err", 128'(err_cnt), 128'(0));
        repeat (10) step();
        run("post_rst", 1'b0, 16'd1, PT, FIPS, kd0);
        check("post_rst_pass", 128'(pass_d), 128'(1));
        check("post_rst_ct", last_ct, FIPS);

        bsy_force = 1'b1;
        kd0 = kd_n;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        bsy_force = 1'b0;
        RST = 1'b1;
        #1;
        check("irst_kdrdy", 128'(KDrdy), 128'(0));
        step();
        RST = 1'b0;
        check("irst_busy", 128'(busy), 128'(0));
        check("irst_no_kd", 128'(kd_n - kd0), 128'(0));
        repeat (3) step();

        check("kd_back_to_back", 128'(kd_b2b), 128'(0));
        check("kin_din_stable", 128'(stab_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
